// File: rtl/subtrator_serial.sv
// subtrator_serial
//   Bit-serial N-bit subtractor: d = (a - b - bi) mod 2^N, one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//   The operation is framed by a start/busy/done handshake.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a      in   [N-1:0] minuend, captured on accepted start
//   b      in   [N-1:0] subtrahend, captured on accepted start
//   bi     in   borrow-in, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, d/bo/ovf valid
//   d      out  [N-1:0] difference, held until the next operation completes
//   bo     out  final borrow-out (unsigned a < b + bi)
//   ovf    out  two's-complement overflow
//
// Build option
//   SUBTRATOR_OVF_EN  when defined, ovf is computed from the captured sign
//                     bits and the new result; otherwise ovf is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one result bit produced per cycle, N cycles
// DONE  | result presented, done pulse, return to IDLE
module subtrator_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   d_q, d_d;
  logic           bo_q, bo_d;

  logic           x, y, diff_bit, borrow_nxt;
  logic [N-1:0]   res_shift;
  logic           last_bit;

  assign x          = a_q[0];
  assign y          = b_q[0];
  assign diff_bit   = x ^ y ^ borrow_q;
  assign borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);
  // Result bits enter at the MSB so the word is right-aligned after N shifts.
  assign res_shift  = {diff_bit, res_q[N-1:1]};
  assign last_bit   = (cnt_q == CW'(N - 1));

`ifdef SUBTRATOR_OVF_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    d_d      = d_q;
    bo_d     = bo_q;
`ifdef SUBTRATOR_OVF_EN
    sa_d     = sa_q;
    sb_d     = sb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bi;
          cnt_d    = '0;
`ifdef SUBTRATOR_OVF_EN
          sa_d     = a[N-1];
          sb_d     = b[N-1];
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_nxt;
        res_d    = res_shift;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          // Outputs are loaded on the transition so they are valid in DONE.
          d_d     = res_shift;
          bo_d    = borrow_nxt;
`ifdef SUBTRATOR_OVF_EN
          ovf_d   = (sa_q != sb_q) && (res_shift[N-1] != sa_q);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
    end
  end

`ifdef SUBTRATOR_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_subtrator_serial.sv
module tb_subtrator_serial;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bi8 = 1'b0;
  logic       busy8, done8, bo8, ovf8;
  logic [7:0] d8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bi4 = 1'b0;
  logic       busy4, done4, bo4, ovf4;
  logic [3:0] d4;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q8[$];
  exp_t q4[$];

  subtrator_serial #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8), .ovf(ovf8)
  );

  subtrator_serial #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bi(bi4),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic hand);
`ifdef SUBTRATOR_OVF_EN
    return hand;
`else
    return 1'b0;
`endif
  endfunction

  // Reference for the exhaustive 4-bit sweep.
  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    exp_t e;
    int   diff;
    diff  = int'(a) - int'(b) - int'(bi);
    e.d   = 8'(diff & 15);
    e.bo  = (diff < 0);
    e.ovf = ovf_exp((a[3] != b[3]) && (e.d[3] != a[3]));
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("n8_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("n8_d", d8, e.d);
        chk("n8_bo", bo8, e.bo);
        chk("n8_ovf", ovf8, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) chk("n4_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("n4_d", 32'(d4), 32'(e.d[3:0]));
        chk("n4_bo", bo4, e.bo);
        chk("n4_ovf", ovf4, e.ovf);
      end
    end
  end

  // mode 0: plain op; mode 1: re-pulse start with other operands in SHIFT and DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic ebo, input logic eovf_hand,
                     input int mode);
    exp_t e;
    int   cyc;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    e.d = ed; e.bo = ebo; e.ovf = ovf_exp(eovf_hand);
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; bi8 = ~bi;
    chk("busy_after_start", busy8, 1'b1);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1 && cyc == 3) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; bi8 = 1'b1;
      end
      if (cyc == 5) start8 = 1'b0;
    end
    chk("latency", cyc, 8);
    chk("busy_in_done", busy8, 1'b0);
    if (mode == 1) begin
      start8 = 1'b1; a8 = 8'h3C; b8 = 8'hC3; bi8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("idle_after_repulse", {busy8, done8}, 2'b00);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int cyc;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
    q4.push_back(model4(a, b, bi));
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc != 4) chk("n4_latency", cyc, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy8, done8, d8, bo8, ovf8}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    op8(8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    op8(8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1, 0);
    op8(8'h9C, 8'h37, 1'b0, 8'h65, 1'b0, 1'b1, 1);
    op8(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 0);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);

    // Abort mid-operation; the previous result (0x80, bo=1) must be wiped.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h22; bi8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy8, done8, d8, bo8, ovf8}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    op8(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          op4(4'(i), 4'(j), 1'(k));

    repeat (3) @(posedge clk);
    chk("n8_queue_drained", q8.size(), 0);
    chk("n4_queue_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
